edge_counter_bank: RTL and testbench

Parametrised multi-channel edge counter, the successor of the single 32-bit clock-edge counter. Each of CH asynchronous input lines is synchronised, edge-detected in a selectable mode (rise, fall, both), and counted in a WIDTH-bit counter with wrap or saturate behaviour, sticky overflow, synchronous clear and an atomic snapshot of all channels. It serves as the event/clock-measurement block of the CPU test and debug infrastructure, read through a channel-select mux.

---
 rtl/edge_counter_bank.sv | 121 ++++++++++++
 tb/tb_edge_counter_bank.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_counter_bank.sv
// Multi-channel synchronised edge counter with wrap/saturate, sticky
// overflow, synchronous clear and an atomic snapshot of every channel.
module edge_counter_bank #(
  parameter int CH          = 4,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SELW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    sig_in,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             clr,
  input  logic             sat,
  input  logic             snap,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] snap_r,
  output logic [CH-1:0]    ovf,
  output logic [CH-1:0]    edge_pulse
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [SYNC_STAGES-1:0] sync_d [CH];
  logic [CH-1:0]          hist_q;
  logic [CH-1:0]          hist_d;
  logic [WIDTH-1:0]       cnt_q  [CH];
  logic [WIDTH-1:0]       cnt_d  [CH];
  logic [WIDTH-1:0]       shad_q [CH];
  logic [WIDTH-1:0]       shad_d [CH];
  logic [CH-1:0]          ovf_q;
  logic [CH-1:0]          ovf_d;
  logic [CH-1:0]          pulse_q;
  logic [CH-1:0]          pulse_d;

  logic [CH-1:0] sync_out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] qual;

  // bit 0 is the newest sample, the top bit feeds the history flop
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    hist_d  = sync_out;
    rise    = sync_out & ~hist_q;
    fall    = ~sync_out & hist_q;
    qual    = ({CH{mode[0]}} & rise)
            | ({CH{mode[1]}} & fall);
    pulse_d = qual;
  end

  // shadows take the pre-update value, so snap+clr keeps the old count
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      shad_d[i] = snap ? cnt_q[i] : shad_q[i];
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en && qual[i]) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end else begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = sat ? CNT_MAX : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
        shad_q[i] <= '0;
      end
      hist_q  <= '0;
      ovf_q   <= '0;
      pulse_q <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      shad_q  <= shad_d;
      hist_q  <= hist_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
    end
  end

  // unselectable channel numbers fall through to zero
  always_comb begin
    r      = '0;
    snap_r = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel == SELW'(i)) begin
        r      = cnt_q[i];
        snap_r = shad_q[i];
      end
    end
  end

  assign ovf        = ovf_q;
  assign edge_pulse = pulse_q;

endmodule

// File: tb/tb_edge_counter_bank.sv
// Bench for edge_counter_bank: a 32-bit and a 4-bit instance share stimulus
// and are compared every cycle against a sample-delay reference model.
module tb_edge_counter_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  sig;
  logic [1:0]  mode;
  logic        en;
  logic        clr;
  logic        sat;
  logic        snap;
  logic [2:0]  sel;
  logic [31:0] r_a;
  logic [31:0] sr_a;
  logic [3:0]  ovf_a;
  logic [3:0]  ep_a;
  logic [3:0]  r_b;
  logic [3:0]  sr_b;
  logic [3:0]  ovf_b;
  logic [3:0]  ep_b;

  int checks = 0;
  int errors = 0;
  int pc [4];

  edge_counter_bank u_a (
    .clk(clk), .rst(rst), .sig_in(sig), .mode(mode), .en(en),
    .clr(clr), .sat(sat), .snap(snap), .sel(sel[1:0]),
    .r(r_a), .snap_r(sr_a), .ovf(ovf_a), .edge_pulse(ep_a)
  );

  edge_counter_bank #(.CH(4), .WIDTH(4), .SELW(3)) u_b (
    .clk(clk), .rst(rst), .sig_in(sig), .mode(mode), .en(en),
    .clr(clr), .sat(sat), .snap(snap), .sel(sel),
    .r(r_b), .snap_r(sr_b), .ovf(ovf_b), .edge_pulse(ep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // smp[i][k]: sig_in[i] as sampled k+1 clock edges ago
  localparam int S = 2;
  bit     smp   [4][S+1];
  longint m_cnt [2][4];
  longint m_sh  [2][4];
  bit     m_ovf [2][4];
  bit     m_ep  [4];
  longint mx    [2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k <= S; k++) smp[i][k] = 1'b0;
      m_ep[i] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_cnt[d][i] = 0;
        m_sh[d][i]  = 0;
        m_ovf[d][i] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    bit nw, od, q;
    for (int i = 0; i < 4; i++) begin
      nw = smp[i][S-1];
      od = smp[i][S];
      q  = (mode[0] && nw && !od) || (mode[1] && !nw && od);
      m_ep[i] = q;
      for (int d = 0; d < 2; d++) begin
        if (snap) m_sh[d][i] = m_cnt[d][i];
        if (clr) begin
          m_cnt[d][i] = 0;
          m_ovf[d][i] = 1'b0;
        end else if (en && q) begin
          if (m_cnt[d][i] != mx[d]) m_cnt[d][i]++;
          else begin
            m_ovf[d][i] = 1'b1;
            m_cnt[d][i] = sat ? mx[d] : 0;
          end
        end
      end
      for (int k = S; k > 0; k--) smp[i][k] = smp[i][k-1];
      smp[i][0] = sig[i];
    end
  endtask

  task automatic compare_all();
    logic [3:0] eo_a, eo_b, ep;
    longint eb, ebs;
    for (int i = 0; i < 4; i++) begin
      eo_a[i] = m_ovf[0][i];
      eo_b[i] = m_ovf[1][i];
      ep[i]   = m_ep[i];
    end
    eb  = (sel < 4) ? m_cnt[1][sel[1:0]] : 0;
    ebs = (sel < 4) ? m_sh[1][sel[1:0]] : 0;
    check("r_a", r_a, 32'(m_cnt[0][sel[1:0]]));
    check("snap_r_a", sr_a, 32'(m_sh[0][sel[1:0]]));
    check("r_b", {28'd0, r_b}, 32'(eb));
    check("snap_r_b", {28'd0, sr_b}, 32'(ebs));
    check("ovf_a", {28'd0, ovf_a}, {28'd0, eo_a});
    check("ovf_b", {28'd0, ovf_b}, {28'd0, eo_b});
    check("pulse_a", {28'd0, ep_a}, {28'd0, ep});
    check("pulse_b", {28'd0, ep_b}, {28'd0, ep});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    for (int i = 0; i < 4; i++) pc[i] += int'(ep_a[i]);
  endtask

  task automatic flush();
    repeat (4) tick();
  endtask

  task automatic pulses(input int ch, input int n);
    repeat (n) begin
      sig[ch] = 1'b1;
      tick();
      tick();
      sig[ch] = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic clear_pc();
    for (int i = 0; i < 4; i++) pc[i] = 0;
  endtask

  task automatic clr_tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // called just after a tick, so reset lands between clock edges
  task automatic async_reset();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    sig  = '0;
    mode = 2'b01;
    en   = 1'b1;
    clr  = 1'b0;
    sat  = 1'b0;
    snap = 1'b0;
    sel  = '0;
    clear_pc();
    model_reset();
    #2;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // rising mode, five pulses on ch2
    pulses(2, 5);
    flush();
    sel = 3'd2;
    #1;
    check("ch2_rise5", r_a, 32'd5);
    check("ch2_pulses", pc[2], 32'd5);
    sel = 3'd0;
    #1;
    check("ch0_idle", r_a, 32'd0);

    // both, falling, off modes on ch0
    mode = 2'b11;
    pulses(0, 5);
    flush();
    #1;
    check("ch0_both", r_a, 32'd10);
    mode = 2'b10;
    pulses(0, 3);
    flush();
    #1;
    check("ch0_fall", r_a, 32'd13);
    mode = 2'b00;
    clear_pc();
    pulses(0, 2);
    flush();
    #1;
    check("ch0_off", r_a, 32'd13);
    check("off_pulses", pc[0], 32'd0);

    // 4-bit wrap then saturate on ch1
    mode = 2'b01;
    clr_tick();
    pulses(1, 17);
    flush();
    sel = 3'd1;
    #1;
    check("wrap_r", {28'd0, r_b}, 32'd1);
    check("wrap_ovf", {31'd0, ovf_b[1]}, 32'd1);
    clr_tick();
    sat = 1'b1;
    pulses(1, 17);
    flush();
    #1;
    check("sat_r", {28'd0, r_b}, 32'd15);
    check("sat_ovf", {31'd0, ovf_b[1]}, 32'd1);
    clr_tick();
    #1;
    check("clr_r", {28'd0, r_b}, 32'd0);
    check("clr_ovf", {28'd0, ovf_b}, 32'd0);
    sat = 1'b0;

    // snap + clr on the same edge as a qualified edge
    pulses(3, 7);
    flush();
    sig[3] = 1'b1;
    tick();
    tick();
    snap = 1'b1;
    clr  = 1'b1;
    tick();
    snap = 1'b0;
    clr  = 1'b0;
    sel  = 3'd3;
    #1;
    check("snapclr_sr", {28'd0, sr_b}, 32'd7);
    check("snapclr_r", {28'd0, r_b}, 32'd0);
    check("snapclr_ep", {31'd0, ep_b[3]}, 32'd1);
    sig[3] = 1'b0;
    tick();
    tick();
    sig[3] = 1'b1;
    flush();
    #1;
    check("after_r", {28'd0, r_b}, 32'd1);
    check("after_sr", {28'd0, sr_b}, 32'd7);
    sig[3] = 1'b0;
    flush();

    // disabled counting still pulses; out-of-range select
    en = 1'b0;
    clear_pc();
    pulses(2, 4);
    flush();
    sel = 3'd2;
    #1;
    check("en_off_r", r_a, 32'd0);
    check("en_off_pulses", pc[2], 32'd4);
    sel = 3'd5;
    #1;
    check("sel5_r", {28'd0, r_b}, 32'd0);
    check("sel5_sr", {28'd0, sr_b}, 32'd0);
    en = 1'b1;

    // reset mid-count with ch3 held high
    clr_tick();
    pulses(3, 8);
    sig[3] = 1'b1;
    flush();
    sel = 3'd3;
    #1;
    check("pre_rst", r_a, 32'd9);
    async_reset();
    check("rst_r", r_a, 32'd0);
    flush();
    #1;
    check("rel_rise", r_a, 32'd1);

    // randomized traffic
    repeat (1500) begin
      sig  = 4'($urandom);
      mode = 2'($urandom);
      en   = ($urandom_range(0, 7) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      sat  = 1'($urandom);
      snap = ($urandom_range(0, 15) == 0);
      sel  = 3'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
